// File: rtl/tile_layer_mixer.sv
// Multi-layer tile pixel generator and priority mixer for the System86 video path.
// Each layer shifts out a latched planar word; the highest-priority opaque pixel beats the chain.
module tile_layer_mixer #(
  parameter int NUM_LAYERS = 2,
  parameter int PLANES     = 3,
  parameter int PIX        = 4,
  parameter int COLOR_W    = 8,
  parameter int PRI_W      = 3,
  parameter int SEL_W      = 1
) (
  input  logic                             CLK_6M,
  input  logic                             RST_N,
  input  logic [NUM_LAYERS-1:0]            LOAD,
  input  logic [NUM_LAYERS*PLANES*PIX-1:0] GDI,
  input  logic [NUM_LAYERS*COLOR_W-1:0]    CLI_L,
  input  logic                             FLIP,
  input  logic                             PRI_WE,
  input  logic [SEL_W-1:0]                 PRI_SEL,
  input  logic [PRI_W-1:0]                 PRI_DATA,
  input  logic [PRI_W-1:0]                 PRI,
  input  logic [COLOR_W-1:0]               CLI,
  input  logic [PLANES-1:0]                DTI,
  output logic [PRI_W-1:0]                 PRO,
  output logic [COLOR_W-1:0]               CLO,
  output logic [PLANES-1:0]                DTO,
  output logic                             HIT,
  output logic [SEL_W-1:0]                 HIT_ID
);

  // Streaming stage without handshake: one pixel per CLK_6M, outputs are valid every cycle out of reset.

  localparam logic [PLANES-1:0] PEN_CLEAR = '1;

  logic [PIX-1:0]     plane_q [NUM_LAYERS][PLANES];
  logic [COLOR_W-1:0] color_q [NUM_LAYERS];
  logic [PRI_W-1:0]   pri_q   [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] flip_q;
  logic [PLANES-1:0]  pen     [NUM_LAYERS];

  logic [PRI_W-1:0]   mix_pri;
  logic [COLOR_W-1:0] mix_col;
  logic [PLANES-1:0]  mix_pix;
  logic               mix_hit;
  logic [SEL_W-1:0]   mix_id;

  // Load beats shift; shifting pulls in ones so an exhausted word reads as transparent.
  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      flip_q <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        color_q[i] <= '0;
        for (int p = 0; p < PLANES; p++) plane_q[i][p] <= '1;
      end
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (LOAD[i]) begin
          color_q[i] <= CLI_L[i*COLOR_W +: COLOR_W];
          flip_q[i]  <= FLIP;
          for (int p = 0; p < PLANES; p++) plane_q[i][p] <= GDI[(i*PLANES+p)*PIX +: PIX];
        end else begin
          for (int p = 0; p < PLANES; p++) begin
            if (flip_q[i]) plane_q[i][p] <= {1'b1, plane_q[i][p][PIX-1:1]};
            else           plane_q[i][p] <= {plane_q[i][p][PIX-2:0], 1'b1};
          end
        end
      end
    end
  end

  // Out-of-range select values match no layer, so such writes fall away.
  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_LAYERS; i++) pri_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (PRI_WE && (PRI_SEL == SEL_W'(i))) pri_q[i] <= PRI_DATA;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      pen[i] = '0;
      for (int p = 0; p < PLANES; p++) begin
        pen[i][p] = flip_q[i] ? plane_q[i][p][0] : plane_q[i][p][PIX-1];
      end
    end
  end

  // Strictly-greater replacement gives ties to the chain, then to the lower layer.
  always_comb begin
    mix_pri = PRI;
    mix_col = CLI;
    mix_pix = DTI;
    mix_hit = 1'b0;
    mix_id  = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if ((pen[i] != PEN_CLEAR) && (pri_q[i] > mix_pri)) begin
        mix_pri = pri_q[i];
        mix_col = color_q[i];
        mix_pix = pen[i];
        mix_hit = 1'b1;
        mix_id  = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      PRO    <= '0;
      CLO    <= '0;
      DTO    <= '0;
      HIT    <= 1'b0;
      HIT_ID <= '0;
    end else begin
      PRO    <= mix_pri;
      CLO    <= mix_col;
      DTO    <= mix_pix;
      HIT    <= mix_hit;
      HIT_ID <= mix_id;
    end
  end

endmodule

// File: tb/tb_tile_layer_mixer.sv
// Bench for tile_layer_mixer: directed scenarios plus random traffic against a pixel-list model.
// Expected outputs are queued at each clock edge and compared by a separate monitor.
module tb_tile_layer_mixer;

  localparam int L = 2;
  localparam int P = 3;
  localparam int X = 4;
  localparam int C = 8;
  localparam int R = 3;
  localparam int S = 1;
  localparam int W = R + C + P + 1 + S;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [L-1:0]     load;
  logic [L*P*X-1:0] gdi;
  logic [L*C-1:0]   cli_l;
  logic             flip;
  logic             pri_we;
  logic [S-1:0]     pri_sel;
  logic [R-1:0]     pri_data;
  logic [R-1:0]     pri;
  logic [C-1:0]     cli;
  logic [P-1:0]     dti;
  logic [R-1:0]     pro;
  logic [C-1:0]     clo;
  logic [P-1:0]     dto;
  logic             hit;
  logic [S-1:0]     hit_id;

  tile_layer_mixer #(
    .NUM_LAYERS(L), .PLANES(P), .PIX(X), .COLOR_W(C), .PRI_W(R), .SEL_W(S)
  ) dut (
    .CLK_6M(clk), .RST_N(rst_n), .LOAD(load), .GDI(gdi), .CLI_L(cli_l), .FLIP(flip),
    .PRI_WE(pri_we), .PRI_SEL(pri_sel), .PRI_DATA(pri_data),
    .PRI(pri), .CLI(cli), .DTI(dti),
    .PRO(pro), .CLO(clo), .DTO(dto), .HIT(hit), .HIT_ID(hit_id)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // Model: each loaded word becomes a list of pixels in display order, consumed one per edge.
  logic [P-1:0] m_word [L][X];
  int           m_idx  [L];
  logic [C-1:0] m_col  [L];
  logic [R-1:0] m_pri  [L];

  function automatic logic [P-1:0] word_pix(int i, int j);
    logic [P-1:0] px;
    int b;
    b = flip ? j : X - 1 - j;
    for (int p = 0; p < P; p++) px[p] = gdi[(i*P+p)*X + b];
    return px;
  endfunction

  function automatic logic [W-1:0] model_mix();
    int best;
    int best_pri;
    logic [P-1:0] px;
    best = -1;
    best_pri = -1;
    for (int i = 0; i < L; i++) begin
      if (m_idx[i] < X) begin
        px = m_word[i][m_idx[i]];
        if (px != {P{1'b1}} && int'(m_pri[i]) > best_pri) begin
          best = i;
          best_pri = int'(m_pri[i]);
        end
      end
    end
    if (best >= 0 && best_pri > int'(pri))
      return {m_pri[best], m_col[best], m_word[best][m_idx[best]], 1'b1, S'(best)};
    return {pri, cli, dti, 1'b0, {S{1'b0}}};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < L; i++) begin
        m_idx[i] <= X;
        m_col[i] <= '0;
        m_pri[i] <= '0;
      end
    end else begin
      exp_q.push_back(model_mix());
      for (int i = 0; i < L; i++) begin
        if (pri_we && int'(pri_sel) == i) m_pri[i] <= pri_data;
        if (load[i]) begin
          m_col[i] <= cli_l[i*C +: C];
          m_idx[i] <= 0;
          for (int j = 0; j < X; j++) m_word[i][j] <= word_pix(i, j);
        end else if (m_idx[i] < X) begin
          m_idx[i] <= m_idx[i] + 1;
        end
      end
    end
  end

  // scoreboard
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got pri=%0d col=%h pix=%0d hit=%0d id=%0d, expected pri=%0d col=%h pix=%0d hit=%0d id=%0d",
               name, $time, act[W-1 -: R], act[W-R-1 -: C], act[S+1 +: P], act[S], act[S-1:0],
               exp[W-1 -: R], exp[W-R-1 -: C], exp[S+1 +: P], exp[S], exp[S-1:0]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check("mix_out", {pro, clo, dto, hit, hit_id}, exp_q.pop_front());
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    load   = '0;
    pri_we = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic load_layer(input int l, input logic [X-1:0] w2, input logic [X-1:0] w1,
                            input logic [X-1:0] w0, input logic [C-1:0] col);
    load[l] = 1'b1;
    gdi[(l*P+0)*X +: X] = w0;
    gdi[(l*P+1)*X +: X] = w1;
    gdi[(l*P+2)*X +: X] = w2;
    cli_l[l*C +: C] = col;
  endtask

  task automatic write_pri(input int sel, input logic [R-1:0] data);
    pri_we   = 1'b1;
    pri_sel  = S'(sel);
    pri_data = data;
  endtask

  initial begin
    rst_n = 1'b0;
    load = '0; gdi = '0; cli_l = '0; flip = 1'b0;
    pri_we = 1'b0; pri_sel = '0; pri_data = '0;
    pri = 3'd1; cli = 8'h55; dti = 3'd2;

    // reset and chain pass-through
    repeat (3) begin
      @(negedge clk);
      check("reset_out", {pro, clo, dto, hit, hit_id}, '0);
    end
    rst_n = 1'b1;
    steps(2);

    // single layer word, no flip, then exhaustion back to the chain
    write_pri(0, 3'd5);
    step();
    load_layer(0, 4'b0000, 4'b0000, 4'b1010, 8'h12);
    steps(6);

    // flipped word; FLIP changing mid-word must not disturb it
    flip = 1'b1;
    load_layer(0, 4'b0000, 4'b0000, 4'b1010, 8'h12);
    step();
    flip = 1'b0;
    steps(5);

    // layer priority, tie between layers, then a transparent pixel on the winner
    write_pri(0, 3'd3);
    step();
    write_pri(1, 3'd3);
    step();
    load_layer(0, 4'b0000, 4'b0110, 4'b0101, 8'hA0);
    load_layer(1, 4'b1001, 4'b0000, 4'b0011, 8'hB1);
    step();
    write_pri(1, 3'd4);
    steps(3);
    load_layer(0, 4'b0011, 4'b0000, 4'b1100, 8'hA0);
    load_layer(1, 4'b0100, 4'b0100, 4'b0100, 8'hB1);
    steps(5);

    // chain wins a tie, layer wins once strictly higher
    pri = 3'd5; cli = 8'h77; dti = 3'd7;
    write_pri(0, 3'd5);
    load_layer(0, 4'b0000, 4'b0000, 4'b0000, 8'hC3);
    steps(2);
    write_pri(0, 3'd6);
    steps(4);

    // reload mid-word, priority write coinciding with a load
    load_layer(0, 4'b1111, 4'b0000, 4'b1010, 8'h21);
    steps(2);
    load_layer(0, 4'b0001, 4'b0010, 4'b0100, 8'h34);
    write_pri(0, 3'd7);
    steps(5);

    // asynchronous reset mid-word
    load_layer(0, 4'b0000, 4'b0000, 4'b0000, 8'h99);
    steps(2);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {pro, clo, dto, hit, hit_id}, '0);
    @(negedge clk);
    check("reset_hold", {pro, clo, dto, hit, hit_id}, '0);
    rst_n = 1'b1;
    steps(5);

    // random traffic
    repeat (400) begin
      pri  = R'($urandom_range(0, 7));
      cli  = C'($urandom_range(0, 255));
      dti  = P'($urandom_range(0, 7));
      flip = 1'($urandom_range(0, 1));
      for (int l = 0; l < L; l++) begin
        if ($urandom_range(0, 3) == 0)
          load_layer(l, X'($urandom), X'($urandom), X'($urandom), C'($urandom));
      end
      if ($urandom_range(0, 3) == 0) write_pri($urandom_range(0, L - 1), R'($urandom_range(0, 7)));
      step();
    end
    steps(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_layer_mixer.md
# tile_layer_mixer

Parametrised multi-layer tile pixel generator and priority mixer for the System86 video path. It is a generalised successor to the dual tilemap generator. It holds `NUM_LAYERS` independent planar shift buffers, each with a latched colour attribute, per-layer programmable priority and per-word horizontal flip. Every pixel clock it selects the highest-priority opaque layer against a daisy-chained upstream pixel and drives the registered result to the next stage (further mixers or the palette lookup).

## Interface
Parameters:
- `NUM_LAYERS`, 2: number of tile layers (1..8).
- `PLANES`, 3: bitplanes per pixel; the pen value 2^PLANES-1 is transparent.
- `PIX`, 4: pixels per fetched word, i.e. shift depth.
- `COLOR_W`, 8: colour attribute width.
- `PRI_W`, 3: priority width.
- `SEL_W`, 1: layer-select width; must be ≥ clog2(NUM_LAYERS).

Ports:
- `CLK_6M` in 1: pixel clock. One clock domain; every register is clocked on its rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `LOAD` in NUM_LAYERS: per-layer word load strobe, sampled on the clock edge.
- `GDI` in NUM_LAYERS*PLANES*PIX: per-layer graphics words. Layer i, plane p occupies bits [(i*PLANES+p)*PIX +: PIX].
- `CLI_L` in NUM_LAYERS*COLOR_W: per-layer colour attribute, latched with `LOAD`.
- `FLIP` in 1: horizontal flip, latched per layer with `LOAD`.
- `PRI_WE` in 1: priority register write strobe.
- `PRI_SEL` in SEL_W: index of the layer whose priority is written.
- `PRI_DATA` in PRI_W: priority value to write.
- `PRI` in PRI_W: upstream chain priority.
- `CLI` in COLOR_W: upstream chain colour.
- `DTI` in PLANES: upstream chain pixel.
- `PRO` out PRI_W: registered output priority.
- `CLO` out COLOR_W: registered output colour.
- `DTO` out PLANES: registered output pixel.
- `HIT` out 1: registered; 1 when a layer, not the chain input, supplied the pixel.
- `HIT_ID` out SEL_W: registered index of the winning layer; 0 when `HIT`=0.

## Operation
- **Per-layer state:** PLANES shift registers of PIX bits, a colour register (COLOR_W), a flip bit, and a priority register (PRI_W).
- **Load:** `LOAD[i]`=1 at an edge does all of the following:
  - Plane registers take that layer's `GDI` slice.
  - Colour register takes its `CLI_L` slice.
  - Flip bit takes `FLIP`.
  - Load has precedence over shift, so reloading mid-word discards the remaining pixels.
- **Shift:** when `LOAD[i]`=0, every plane register shifts by one each cycle.
  - flip=0: shift left, current pixel is bit PIX-1.
  - flip=1: shift right, current pixel is bit 0.
  - The vacated bit fills with 1. After PIX shifts without a reload, the layer's pen is all-ones, i.e. transparent until the next load.
- **Layer pixel:** {plane PLANES-1 … plane 0} current bits.
- **Priority write:** `PRI_WE`=1 writes `PRI_DATA` into priority[`PRI_SEL`]. A write with `PRI_SEL` ≥ NUM_LAYERS is ignored.
- **Mix (combinational, registered to outputs):**
  - Start candidate = {`PRI`, `CLI`, `DTI`}, hit=0.
  - Scan layers from index 0 upward. Layer i replaces the candidate only if its pixel ≠ 2^PLANES-1 and its priority is strictly greater than the candidate priority.
  - Ties therefore go to the chain input first, then to the lower layer index.
  - The chain pixel is passed through even if it is transparent; downstream decides.
- **Reset state:**
  - All outputs 0 (`PRO`, `CLO`, `DTO`, `HIT`, `HIT_ID`).
  - Plane registers all-ones (transparent).
  - Colour 0, flip 0, priorities 0.

## Timing
- **Load latency:** `LOAD[i]` at edge k makes word pixel 0 visible in the mix during cycle k→k+1. It reaches the outputs at edge k+1, and pixel j at edge k+1+j.
- **Reload:** continuous back-to-back loads every PIX cycles give a gapless pixel stream.
- **Priority write latency:** a write at edge k affects the outputs from edge k+1 onward.
- **Flip:** a change on `FLIP` without a `LOAD` has no effect on a word already in flight.
- **Chain latency:** the chain inputs are sampled combinationally, giving 1 cycle from `PRI`/`CLI`/`DTI` to the outputs.
- **Reset:** asserting `RST_N` low mid-word clears everything immediately, with no clock needed. The first edge after release outputs the chain input.
- **Simultaneous events:** loads on several layers in the same edge are independent. A `PRI_WE` in the same edge as `LOAD` on the same layer applies both.

## Test plan
All scenarios use default parameters.

1. **Reset and chain pass-through.** Assert `RST_N`=0, then drive `PRI`=1, `CLI`=0x55, `DTI`=2. Outputs must be all 0 while in reset. After release, the first edge gives `PRO`=1, `CLO`=0x55, `DTO`=2, `HIT`=0.
2. **Single-layer word, no flip.** Write priority0=5, hold `PRI`=1, `FLIP`=0. Load layer 0 with plane0=4'b1010, planes 1 and 2 = 0, `CLI_L`=0x12.
   - Edges k+1..k+4: `DTO`=1,0,1,0 with `CLO`=0x12, `HIT`=1, `HIT_ID`=0.
   - Edge k+5: chain values reappear with `HIT`=0.
3. **Same word with `FLIP`=1.** `DTO`=0,1,0,1.
4. **Layer priority.** Load both layers with opaque words, priorities 3 and 3: layer 0 wins. Set priority1=4 (written at edge k): layer 1 wins from edge k+1. Load layer 1 with pen 7 at one pixel: that pixel shows layer 0.
5. **Chain tie.** `PRI`=5, layer 0 at priority 5 and opaque: chain wins, `HIT`=0. Write priority0=6: layer wins.
6. **Reload and reset mid-word.** `LOAD` at pixel 2 of a word restarts the stream with the new pixel 0 at the next edge. `RST_N` pulsed low mid-word zeroes outputs asynchronously, and the stream is transparent afterwards.
